// File: rtl/operand_entry.sv
//------------------------------------------------------------------------------
// Module   : operand_entry
// Purpose  : Builds two BCD operands and an opcode from key events, then
//            converts the operands to binary and pulses go to the ALU.
// Options  : KEY_SYNC_EN - treat key_stb as an asynchronous level and
//            synchronise/edge-detect it internally.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module operand_entry #(
  parameter int NDIG  = 4,
  parameter int BIN_W = 14
) (
  input  logic                 CLK100MHZ,
  input  logic                 RESET,
  input  logic [3:0]           key_code,
  input  logic                 key_valid,
  input  logic                 key_stb,
  output logic [4*NDIG-1:0]    bcd_a,
  output logic [4*NDIG-1:0]    bcd_b,
  output logic [3:0]           opcode,
  output logic [1:0]           sel,
  output logic [BIN_W-1:0]     bin_a,
  output logic [BIN_W-1:0]     bin_b,
  output logic                 go,
  output logic                 busy
);

  localparam int               CNT_W       = $clog2(NDIG + 1);
  localparam logic [CNT_W-1:0] C_NDIG      = CNT_W'(NDIG);
  localparam logic [CNT_W-1:0] C_LAST      = CNT_W'(NDIG - 1);
  localparam logic [3:0]       C_KEY_A     = 4'd10;
  localparam logic [3:0]       C_KEY_B     = 4'd11;
  localparam logic [3:0]       C_KEY_OP    = 4'd12;
  localparam logic [3:0]       C_KEY_BS    = 4'd13;
  localparam logic [3:0]       C_KEY_ENTER = 4'd14;
  localparam logic [1:0]       C_SEL_A     = 2'd0;
  localparam logic [1:0]       C_SEL_B     = 2'd1;
  localparam logic [1:0]       C_SEL_OP    = 2'd2;

  typedef enum logic [1:0] {
    S_EDIT = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [4*NDIG-1:0]     r_bcd_a;
  logic [4*NDIG-1:0]     r_bcd_b;
  logic [CNT_W-1:0]      r_cnt_a;
  logic [CNT_W-1:0]      r_cnt_b;
  logic [3:0]            r_op;
  logic [1:0]            r_sel;
  logic [CNT_W-1:0]      r_idx;
  logic [BIN_W-1:0]      r_acc_a;
  logic [BIN_W-1:0]      r_acc_b;
  logic [BIN_W-1:0]      r_bin_a;
  logic [BIN_W-1:0]      r_bin_b;
  logic                  w_stb;
  logic                  w_evt;
  logic                  w_is_digit;
  logic [4*NDIG-1:0]     w_sh_a;
  logic [4*NDIG-1:0]     w_sh_b;
  logic [BIN_W-1:0]      w_acc_a_nxt;
  logic [BIN_W-1:0]      w_acc_b_nxt;

`ifdef KEY_SYNC_EN
  // bits [1:0] are the synchroniser, bit 2 holds the previous level for edge detect
  logic [2:0] r_stb_sync;

  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) r_stb_sync <= 3'b000;
    else       r_stb_sync <= {r_stb_sync[1:0], key_stb};
  end

  assign w_stb = r_stb_sync[1] & ~r_stb_sync[2];
`else
  assign w_stb = key_stb;
`endif

  assign w_evt      = w_stb && key_valid && (r_state == S_EDIT);
  assign w_is_digit = (key_code <= 4'd9);

  // Digit under conversion, MS digit first, for both operands in parallel
  assign w_sh_a      = r_bcd_a >> {r_idx, 2'b00};
  assign w_sh_b      = r_bcd_b >> {r_idx, 2'b00};
  assign w_acc_a_nxt = (r_acc_a << 3) + (r_acc_a << 1) + {{(BIN_W-4){1'b0}}, w_sh_a[3:0]};
  assign w_acc_b_nxt = (r_acc_b << 3) + (r_acc_b << 1) + {{(BIN_W-4){1'b0}}, w_sh_b[3:0]};

  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) r_state <= S_EDIT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EDIT:  if (w_evt && key_code == C_KEY_ENTER) w_state_nxt = S_CONV;
      S_CONV:  if (r_idx == '0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_EDIT;
      default: w_state_nxt = S_EDIT;
    endcase
  end

  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) begin
      r_bcd_a <= '0;
      r_bcd_b <= '0;
      r_cnt_a <= '0;
      r_cnt_b <= '0;
      r_op    <= '0;
      r_sel   <= C_SEL_A;
      r_idx   <= '0;
      r_acc_a <= '0;
      r_acc_b <= '0;
      r_bin_a <= '0;
      r_bin_b <= '0;
    end else if (r_state == S_CONV) begin
      r_acc_a <= w_acc_a_nxt;
      r_acc_b <= w_acc_b_nxt;
      r_idx   <= r_idx - CNT_W'(1);
      if (r_idx == '0) begin
        r_bin_a <= w_acc_a_nxt;
        r_bin_b <= w_acc_b_nxt;
      end
    end else if (w_evt) begin
      if (w_is_digit) begin
        if (r_sel == C_SEL_A && r_cnt_a < C_NDIG) begin
          r_bcd_a <= {r_bcd_a[4*NDIG-5:0], key_code};
          r_cnt_a <= r_cnt_a + CNT_W'(1);
        end else if (r_sel == C_SEL_B && r_cnt_b < C_NDIG) begin
          r_bcd_b <= {r_bcd_b[4*NDIG-5:0], key_code};
          r_cnt_b <= r_cnt_b + CNT_W'(1);
        end else if (r_sel == C_SEL_OP) begin
          r_op <= key_code;
        end
      end else if (key_code == C_KEY_A) begin
        r_sel <= C_SEL_A;
      end else if (key_code == C_KEY_B) begin
        r_sel <= C_SEL_B;
      end else if (key_code == C_KEY_OP) begin
        r_sel <= C_SEL_OP;
      end else if (key_code == C_KEY_BS) begin
        if (r_sel == C_SEL_A && r_cnt_a != '0) begin
          r_bcd_a <= {4'h0, r_bcd_a[4*NDIG-1:4]};
          r_cnt_a <= r_cnt_a - CNT_W'(1);
        end else if (r_sel == C_SEL_B && r_cnt_b != '0) begin
          r_bcd_b <= {4'h0, r_bcd_b[4*NDIG-1:4]};
          r_cnt_b <= r_cnt_b - CNT_W'(1);
        end else if (r_sel == C_SEL_OP) begin
          r_op <= 4'h0;
        end
      end else if (key_code == C_KEY_ENTER) begin
        r_acc_a <= '0;
        r_acc_b <= '0;
        r_idx   <= C_LAST;
      end
    end
  end

  assign bcd_a  = r_bcd_a;
  assign bcd_b  = r_bcd_b;
  assign opcode = r_op;
  assign sel    = r_sel;
  assign bin_a  = r_bin_a;
  assign bin_b  = r_bin_b;
  assign go     = (r_state == S_DONE);
  assign busy   = (r_state != S_EDIT);

endmodule

`default_nettype wire

// File: tb/tb_operand_entry.sv
//------------------------------------------------------------------------------
// Module   : tb_operand_entry
// Purpose  : Self-checking bench for operand_entry against a digit-queue model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_operand_entry;

  localparam int NDIG  = 4;
  localparam int BIN_W = 14;

  logic               CLK100MHZ = 1'b0;
  logic               RESET     = 1'b1;
  logic [3:0]         key_code  = 4'h0;
  logic               key_valid = 1'b0;
  logic               key_stb   = 1'b0;
  logic [4*NDIG-1:0]  bcd_a;
  logic [4*NDIG-1:0]  bcd_b;
  logic [3:0]         opcode;
  logic [1:0]         sel;
  logic [BIN_W-1:0]   bin_a;
  logic [BIN_W-1:0]   bin_b;
  logic               go;
  logic               busy;

  operand_entry #(.NDIG(NDIG), .BIN_W(BIN_W)) dut (
    .CLK100MHZ (CLK100MHZ),
    .RESET     (RESET),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_stb   (key_stb),
    .bcd_a     (bcd_a),
    .bcd_b     (bcd_b),
    .opcode    (opcode),
    .sel       (sel),
    .bin_a     (bin_a),
    .bin_b     (bin_b),
    .go        (go),
    .busy      (busy)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model: entered digits per operand, most significant first
  int qa[$];
  int qb[$];
  int m_sel = 0;
  int m_op  = 0;

  function automatic int pack_bcd(input int q[$]);
    int r = 0;
    foreach (q[i]) r = r * 16 + q[i];
    return r;
  endfunction

  function automatic int dec_val(input int q[$]);
    int r = 0;
    foreach (q[i]) r = r * 10 + q[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK100MHZ);
    #1;
  endtask

  // Returns one cycle after the edge on which the DUT acts on the event
  task automatic press(input int k, input logic v);
    key_code  = 4'(k);
    key_valid = v;
    key_stb   = 1'b1;
    tick();
    key_stb   = 1'b0;
`ifdef KEY_SYNC_EN
    tick();
    tick();
`endif
    key_valid = 1'b0;
  endtask

  task automatic model_key(input int k);
    if (k <= 9) begin
      if (m_sel == 0 && qa.size() < NDIG) qa.push_back(k);
      else if (m_sel == 1 && qb.size() < NDIG) qb.push_back(k);
      else if (m_sel == 2) m_op = k;
    end else if (k >= 10 && k <= 12) begin
      m_sel = k - 10;
    end else if (k == 13) begin
      if (m_sel == 0 && qa.size() > 0) void'(qa.pop_back());
      else if (m_sel == 1 && qb.size() > 0) void'(qb.pop_back());
      else if (m_sel == 2) m_op = 0;
    end
  endtask

  task automatic key(input int k);
    press(k, 1'b1);
    model_key(k);
  endtask

  task automatic check_fields(input string tag);
    chk({tag, "_bcd_a"}, 32'(bcd_a), pack_bcd(qa));
    chk({tag, "_bcd_b"}, 32'(bcd_b), pack_bcd(qb));
    chk({tag, "_op"},    32'(opcode), m_op);
    chk({tag, "_sel"},   32'(sel),    m_sel);
  endtask

  // Remaining cycles until go, given how many CONV cycles already elapsed
  task automatic wait_go(input string tag, input int expect_n);
    int n = 0;
    while (!go && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"},   n, expect_n);
    chk({tag, "_bin_a"}, 32'(bin_a), dec_val(qa));
    chk({tag, "_bin_b"}, 32'(bin_b), dec_val(qb));
    chk({tag, "_op"},    32'(opcode), m_op);
    tick();
    chk({tag, "_go_off"},   32'(go),   0);
    chk({tag, "_busy_off"}, 32'(busy), 0);
    chk({tag, "_bin_hold"}, 32'(bin_a), dec_val(qa));
  endtask

  task automatic run_enter(input string tag);
    press(14, 1'b1);
    chk({tag, "_busy"}, 32'(busy), 1);
    chk({tag, "_go0"},  32'(go),   0);
    wait_go(tag, NDIG);
  endtask

  initial begin
    logic saw;

    // Reset state
    tick();
    tick();
    chk("rst_bcd_a", 32'(bcd_a), 0);
    chk("rst_bcd_b", 32'(bcd_b), 0);
    chk("rst_op",    32'(opcode), 0);
    chk("rst_sel",   32'(sel),   0);
    chk("rst_bin_a", 32'(bin_a), 0);
    chk("rst_bin_b", 32'(bin_b), 0);
    chk("rst_go",    32'(go),    0);
    chk("rst_busy",  32'(busy),  0);
    RESET = 1'b0;
    tick();

    // Basic entry and conversion
    key(1); key(2); key(3);
    chk("a123", 32'(bcd_a), 32'h0123);
    run_enter("ent123");

    // Full field, fifth digit dropped
    key(13); key(13); key(13);
    key(9); key(9); key(9); key(9); key(8);
    chk("a9999", 32'(bcd_a), 32'h9999);
    key(11); key(4); key(2);
    check_fields("b42");
    run_enter("ent9999");

    // Backspace behaviour
    key(10); key(13); key(13); key(13); key(13);
    key(5); key(6); key(7); key(13); key(13); key(8);
    chk("a0058", 32'(bcd_a), 32'h0058);
    key(13); key(13); key(13);
    check_fields("bs_empty");

    // Opcode field and invalid events
    key(12); key(7); key(12); key(3);
    check_fields("op3");
    key(13);
    check_fields("op_clr");
    press(5, 1'b0);
    press(10, 1'b0);
    press(14, 1'b0);
    check_fields("invalid");
    chk("invalid_busy", 32'(busy), 0);

`ifndef KEY_SYNC_EN
    // Keys during conversion are dropped; second Enter does not re-trigger
    key(10); key(3); key(1);
    press(14, 1'b1);
    press(1, 1'b1);
    press(14, 1'b1);
    wait_go("b2b", NDIG - 2);
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      saw |= go;
    end
    chk("b2b_single_go", 32'(saw), 0);
    check_fields("b2b_kept");
    run_enter("reenter");
`endif

    // Asynchronous reset in the middle of conversion
    key(10); key(7);
    press(14, 1'b1);
    tick();
    RESET = 1'b1;
    #1;
    chk("mid_rst_bcd_a", 32'(bcd_a), 0);
    chk("mid_rst_bin_a", 32'(bin_a), 0);
    chk("mid_rst_busy",  32'(busy),  0);
    chk("mid_rst_go",    32'(go),    0);
    chk("mid_rst_sel",   32'(sel),   0);
    qa.delete();
    qb.delete();
    m_sel = 0;
    m_op  = 0;
    tick();
    RESET = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      saw |= go;
    end
    chk("mid_rst_no_go", 32'(saw), 0);

`ifdef KEY_SYNC_EN
    // Level change of key_stb takes effect two cycles later
    key_code  = 4'd5;
    key_valid = 1'b1;
    key_stb   = 1'b1;
    tick();
    chk("sync_lat1", 32'(bcd_a), 0);
    key_stb = 1'b0;
    tick();
    chk("sync_lat2", 32'(bcd_a), 0);
    tick();
    chk("sync_lat3", 32'(bcd_a), 32'h0005);
    key_valid = 1'b0;
    qa.push_back(5);
`endif

    // Randomised key traffic
    for (int it = 0; it < 150; it++) begin
      int   k;
      logic v;
      k = $urandom_range(0, 14);
      v = ($urandom_range(0, 5) != 0);
      if (v && k == 14) run_enter("rnd_ent");
      else if (v) key(k);
      else press(k, 1'b0);
      check_fields("rnd");
    end
    run_enter("final_ent");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
